bcd_tick_stopwatch: RTL and testbench

//  Downstream consumer of the one-cycle pulse produced by the clock_50 pulse divider.

---
 rtl/bcd_tick_stopwatch_if.sv | 47 ++++
 rtl/bcd_tick_stopwatch.sv | 151 +++++++++++++++
 tb/tb_bcd_tick_stopwatch.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_tick_stopwatch_if.sv
// ---------------------------------------------------------------------------
// bcd_tick_stopwatch_if
//   Groups the control inputs and display/status outputs of the BCD stopwatch.
//
//   Handshake: there is no valid/ready pair. tick is a single-cycle qualifier
//   that is meaningful on every rising clock edge it is high. start_stop is a
//   level whose rising edge is detected inside the block. clear is a level
//   sampled every edge. All outputs are valid continuously; wrap is a
//   single-cycle pulse.
//
//   Signals
//     tick        1  count-enable pulse from the upstream divider
//     start_stop  1  level; each rising edge toggles run/pause
//     clear       1  synchronous clear back to IDLE / 00.0
//     running     1  high while the FSM is in RUN
//     bcd0..bcd2  4  tenths, seconds, tens-of-seconds digits
//     wrap        1  one-cycle pulse on rollover to 00.0
//     hex0..hex2  7  active-low segments {g,f,e,d,c,b,a}
//     fsm_state   2  debug view of the FSM state register
//
//   Modports: master drives the controls (testbench / board glue),
//             slave is the stopwatch itself.
// ---------------------------------------------------------------------------
interface bcd_tick_stopwatch_if;
  logic       tick;
  logic       start_stop;
  logic       clear;
  logic       running;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic       wrap;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [1:0] fsm_state;

  modport master (
    output tick, start_stop, clear,
    input  running, bcd0, bcd1, bcd2, wrap, hex0, hex1, hex2, fsm_state
  );

  modport slave (
    input  tick, start_stop, clear,
    output running, bcd0, bcd1, bcd2, wrap, hex0, hex1, hex2, fsm_state
  );
endinterface

// File: rtl/bcd_tick_stopwatch.sv
// ---------------------------------------------------------------------------
// bcd_tick_stopwatch
//   Three-digit BCD stopwatch (SS.t) counting one-cycle tick pulses.
//   A small IDLE/RUN/PAUSED FSM is toggled by rising edges of start_stop and
//   forced back to IDLE by clear. Digits drive active-low 7-segment displays,
//   and a one-cycle wrap pulse marks the MAX_TENS9.9 -> 00.0 rollover.
//
//   Ports
//     clock_50  in  system clock, rising edge
//     resetn    in  asynchronous active-low reset
//     sw        slave modport of bcd_tick_stopwatch_if (controls + outputs)
//
//   Parameter
//     MAX_TENS  highest tens-of-seconds digit before wrap (1..9)
// ---------------------------------------------------------------------------
module bcd_tick_stopwatch #(
  parameter int unsigned MAX_TENS = 5
) (
  input  logic                  clock_50,
  input  logic                  resetn,
  bcd_tick_stopwatch_if.slave   sw
);

  localparam logic [3:0] MAX_TENS_L = 4'(MAX_TENS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       ss_q;            // start_stop delayed by one cycle for edge detect
  logic [3:0] bcd0_q, bcd0_d;
  logic [3:0] bcd1_q, bcd1_d;
  logic [3:0] bcd2_q, bcd2_d;
  logic       wrap_q, wrap_d;

  logic       rise;
  logic       count_en;

  assign rise = sw.start_stop & ~ss_q;

  // Counting looks at the registered state only, so a tick arriving with the
  // IDLE->RUN edge is dropped while one arriving with RUN->PAUSED still counts.
  assign count_en = (state_q == RUN) & ~sw.clear & sw.tick;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ss_q    <= 1'b0;
      bcd0_q  <= 4'd0;
      bcd1_q  <= 4'd0;
      bcd2_q  <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= sw.start_stop;
      bcd0_q  <= bcd0_d;
      bcd1_q  <= bcd1_d;
      bcd2_q  <= bcd2_d;
      wrap_q  <= wrap_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state; clear wins over any start_stop edge
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (sw.clear) begin
      state_d = IDLE;
    end else if (rise) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSED;
        PAUSED:  state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // BCD counter with ripple carry between digits
  // -------------------------------------------------------------------------
  always_comb begin
    bcd0_d = bcd0_q;
    bcd1_d = bcd1_q;
    bcd2_d = bcd2_q;
    wrap_d = 1'b0;
    if (sw.clear) begin
      bcd0_d = 4'd0;
      bcd1_d = 4'd0;
      bcd2_d = 4'd0;
    end else if (count_en) begin
      // >= rather than == keeps the counter self-correcting toward legal codes
      if (bcd0_q >= 4'd9) begin
        bcd0_d = 4'd0;
        if (bcd1_q >= 4'd9) begin
          bcd1_d = 4'd0;
          if (bcd2_q >= MAX_TENS_L) begin
            bcd2_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            bcd2_d = bcd2_q + 4'd1;
          end
        end else begin
          bcd1_d = bcd1_q + 4'd1;
        end
      end else begin
        bcd0_d = bcd0_q + 4'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Active-low 7-segment decode {g,f,e,d,c,b,a}; non-BCD codes blank
  // -------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b1111111;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign sw.running   = (state_q == RUN);
  assign sw.bcd0      = bcd0_q;
  assign sw.bcd1      = bcd1_q;
  assign sw.bcd2      = bcd2_q;
  assign sw.wrap      = wrap_q;
  assign sw.hex0      = seg7(bcd0_q);
  assign sw.hex1      = seg7(bcd1_q);
  assign sw.hex2      = seg7(bcd2_q);
  assign sw.fsm_state = state_q;

endmodule

// File: tb/tb_bcd_tick_stopwatch.sv
// ---------------------------------------------------------------------------
// tb_bcd_tick_stopwatch
//   Self-checking bench for bcd_tick_stopwatch (MAX_TENS = 5).
//   The expected count is kept as a plain decimal integer modulo 600 and
//   converted to digits with / and %; every driven cycle pushes its expected
//   {wrap, bcd2, bcd1, bcd0} and the value is popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_tick_stopwatch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  bcd_tick_stopwatch_if sw_if ();

  bcd_tick_stopwatch #(.MAX_TENS(5)) dut (
    .clock_50 (clk),
    .resetn   (resetn),
    .sw       (sw_if.slave)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [12:0] exp_q[$];
  int          model_count = 0;
  bit          model_run   = 1'b0;
  bit          model_ss    = 1'b0;
  logic [6:0]  seg_tab [10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] pack_exp(input int c, input bit w);
    return {w, 4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; inputs are applied 1 time unit after an edge and
  // the result is compared 1 time unit after the next edge.
  task automatic cycle(input bit t, input bit s, input bit c, input string tag);
    logic [12:0] e;
    logic [12:0] got;
    bit          rise;
    bit          w;
    sw_if.tick       = t;
    sw_if.start_stop = s;
    sw_if.clear      = c;
    rise     = s && !model_ss;
    model_ss = s;
    w        = 1'b0;
    if (c) begin
      model_count = 0;
      model_run   = 1'b0;
    end else begin
      if (t && model_run) begin
        model_count = (model_count + 1) % 600;
        w = (model_count == 0);
      end
      if (rise) model_run = !model_run;
    end
    exp_q.push_back(pack_exp(model_count, w));
    step();
    sw_if.tick  = 1'b0;
    sw_if.clear = 1'b0;
    got = {sw_if.wrap, sw_if.bcd2, sw_if.bcd1, sw_if.bcd0};
    e   = exp_q.pop_front();
    check(tag, 32'(got), 32'(e));
    check({tag, "_running"}, 32'(sw_if.running), 32'(model_run));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic do_rise();
    cycle(1'b0, 1'b1, 1'b0, "rise");
    cycle(1'b0, 1'b0, 1'b0, "rise_low");
  endtask

  task automatic do_clear();
    cycle(1'b0, 1'b0, 1'b1, "clear");
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      cycle(1'b1, 1'b0, 1'b0, "tick");
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic check_hex(input string tag);
    check({tag, "_hex0"}, 32'(sw_if.hex0), 32'(seg_tab[model_count % 10]));
    check({tag, "_hex1"}, 32'(sw_if.hex1), 32'(seg_tab[(model_count / 10) % 10]));
    check({tag, "_hex2"}, 32'(sw_if.hex2), 32'(seg_tab[model_count / 100]));
  endtask

  task automatic check_digits(input string tag, input int d2, input int d1, input int d0);
    check({tag, "_bcd2"}, 32'(sw_if.bcd2), 32'(d2));
    check({tag, "_bcd1"}, 32'(sw_if.bcd1), 32'(d1));
    check({tag, "_bcd0"}, 32'(sw_if.bcd0), 32'(d0));
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_running"}, 32'(sw_if.running), 32'd0);
    check({tag, "_wrap"},    32'(sw_if.wrap),    32'd0);
    check_digits(tag, 0, 0, 0);
    check({tag, "_hex0"}, 32'(sw_if.hex0), 32'h40);
    check({tag, "_hex1"}, 32'(sw_if.hex1), 32'h40);
    check({tag, "_hex2"}, 32'(sw_if.hex2), 32'h40);
    check({tag, "_state"}, 32'(sw_if.fsm_state), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    sw_if.tick       = 1'b0;
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    resetn           = 1'b1;

    // 1: reset with random inputs, checked before and after clock edges
    #1 resetn = 1'b0;
    #1 check_zero_state("reset_noclk");
    repeat (4) begin
      sw_if.tick       = 1'($urandom_range(0, 1));
      sw_if.start_stop = 1'($urandom_range(0, 1));
      sw_if.clear      = 1'($urandom_range(0, 1));
      step();
      check_zero_state("reset_rand");
    end
    sw_if.tick       = 1'b0;
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    step();
    resetn = 1'b1;
    step();

    // 2: start and count 25 spaced ticks
    do_rise();
    ticks(25, 9);
    check_digits("count25", 0, 2, 5);
    check("count25_hex0", 32'(sw_if.hex0), 32'b0010010);
    check("count25_hex1", 32'(sw_if.hex1), 32'b0100100);
    check_hex("count25");

    // 3: pause holds digits, resume continues
    do_clear();
    do_rise();
    ticks(3, 1);
    do_rise();
    check("pause_running", 32'(sw_if.running), 32'd0);
    check("pause_state", 32'(sw_if.fsm_state), 32'd2);
    ticks(5, 1);
    check_digits("pause_hold", 0, 0, 3);
    do_rise();
    check("resume_running", 32'(sw_if.running), 32'd1);
    ticks(1, 1);
    check_digits("resume", 0, 0, 4);
    // tick together with RUN->PAUSED edge is still counted
    cycle(1'b1, 1'b1, 1'b0, "tick_with_pause");
    idle(1);
    ticks(2, 0);
    check_digits("pause_edge_tick", 0, 0, 5);

    // 4: wrap from 59.9
    do_clear();
    do_rise();
    ticks(599, 0);
    check_digits("preload", 5, 9, 9);
    check_hex("preload");
    cycle(1'b1, 1'b0, 1'b0, "wrap_tick");
    check("wrap_pulse", 32'(sw_if.wrap), 32'd1);
    check_digits("wrap", 0, 0, 0);
    idle(1);
    check("wrap_drop", 32'(sw_if.wrap), 32'd0);
    ticks(1, 0);
    check_digits("after_wrap", 0, 0, 1);

    // 5: collisions
    do_clear();
    do_rise();
    ticks(123, 0);
    check_digits("pre_collide", 1, 2, 3);
    cycle(1'b1, 1'b1, 1'b1, "clear_tick_rise");
    check_zero_state("collide");
    idle(1);
    cycle(1'b1, 1'b1, 1'b0, "idle_rise_tick");
    check_digits("idle_rise_tick", 0, 0, 0);
    check("idle_rise_running", 32'(sw_if.running), 32'd1);
    idle(1);

    // 6: asynchronous reset mid-count, start_stop held high through release
    do_clear();
    do_rise();
    ticks(345, 0);
    check_digits("pre_reset", 3, 4, 5);
    #2;
    resetn           = 1'b0;
    sw_if.start_stop = 1'b1;
    #1 check_zero_state("async_reset");
    step();
    step();
    resetn      = 1'b1;
    model_count = 0;
    model_run   = 1'b0;
    model_ss    = 1'b0;
    exp_q.delete();
    repeat (6) cycle(1'b0, 1'b1, 1'b0, "held_level");
    check("held_single_start", 32'(sw_if.fsm_state), 32'd1);
    idle(1);
    ticks(1, 0);
    check_digits("post_reset_count", 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
